// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select encodings
// and the return-address-stack pointer width helper.
package pc_pkg;

  typedef logic [2:0] pcsel_t;

  localparam pcsel_t PCSEL_PLUS4  = 3'd0;
  localparam pcsel_t PCSEL_BRANCH = 3'd1;
  localparam pcsel_t PCSEL_JREG   = 3'd2;
  localparam pcsel_t PCSEL_CALL   = 3'd3;
  localparam pcsel_t PCSEL_RET    = 3'd4;
  localparam pcsel_t PCSEL_TRAP   = 3'd5;

  function automatic int ras_ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode and the PC sequencer.
// Carries the misalign pulse only when PC_MISALIGN_TRAP_EN is defined.
interface pc_sequencer_if #(
  parameter int DBITS = 32
);
  import pc_pkg::*;

  logic             stall;
  pcsel_t           pcSel;
  logic             cmp;
  logic [DBITS-1:0] imm;
  logic [DBITS-1:0] reg1;
  logic [DBITS-1:0] pcOut;
  logic             rasEmpty;
  logic             rasFull;
  logic             rasOvf;
  logic             rasUnf;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misalign;

  modport master (output stall, pcSel, cmp, imm, reg1,
                  input  pcOut, rasEmpty, rasFull, rasOvf, rasUnf, misalign);
  modport slave  (input  stall, pcSel, cmp, imm, reg1,
                  output pcOut, rasEmpty, rasFull, rasOvf, rasUnf, misalign);
`else
  modport master (output stall, pcSel, cmp, imm, reg1,
                  input  pcOut, rasEmpty, rasFull, rasOvf, rasUnf);
  modport slave  (input  stall, pcSel, cmp, imm, reg1,
                  output pcOut, rasEmpty, rasFull, rasOvf, rasUnf);
`endif
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty only raises the sticky underflow flag.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DBITS-1:0] i_data,
  output logic [DBITS-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);
  localparam int PW = ras_ptr_bits(DEPTH);

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~i_stall;
  assign w_do_pop  = i_pop  & ~i_stall;
  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_top     = r_mem[r_ptr - 1'b1];
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;

  // Entries are never reset; only count and pointer define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (o_full) r_ovf   <= 1'b1;
      else        r_count <= r_count + 1'b1;
    end else if (w_do_pop) begin
      if (o_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr   <= r_ptr - 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC mux, PC register and return-address stack.
// Optional PC_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VEC.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int START_PC  = 64,
  parameter int TRAP_VEC  = 16,
  parameter int RAS_DEPTH = 4,
  parameter int IMM_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  pc_sequencer_if.slave bus
);
  logic [DBITS-1:0] r_pc;
  logic [DBITS-1:0] w_pc_next;
  logic [DBITS-1:0] w_seq;
  logic [DBITS-1:0] w_off;
  logic [DBITS-1:0] w_target;
  logic [DBITS-1:0] w_top;
  logic             w_use_target;
  logic             w_trap;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
`ifdef PC_MISALIGN_TRAP_EN
  logic             w_misalign;
  logic             r_misalign;
`endif

  always_comb begin
    w_seq        = r_pc + DBITS'(4);
    w_off        = bus.imm << IMM_SHIFT;
    w_target     = w_seq;
    w_use_target = 1'b0;
    w_trap       = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (bus.pcSel)
      PCSEL_BRANCH: if (bus.cmp) begin
        w_target     = w_seq + w_off;
        w_use_target = 1'b1;
      end
      PCSEL_JREG: begin
        w_target     = bus.reg1 + w_off;
        w_use_target = 1'b1;
      end
      PCSEL_CALL: begin
        w_target     = bus.reg1 + w_off;
        w_use_target = 1'b1;
        w_push       = 1'b1;
      end
      PCSEL_RET: begin
        w_pop = 1'b1;
        if (!w_empty) begin
          w_target     = w_top;
          w_use_target = 1'b1;
        end
      end
      PCSEL_TRAP: w_trap = 1'b1;
      default: ;
    endcase

    w_pc_next = w_seq;
`ifdef PC_MISALIGN_TRAP_EN
    w_misalign = w_use_target && (w_target[1:0] != 2'b00);
    if (w_use_target) w_pc_next = w_misalign ? DBITS'(TRAP_VEC) : w_target;
`else
    if (w_use_target) w_pc_next = w_target & ~DBITS'(3);
`endif
    if (w_trap) w_pc_next = DBITS'(TRAP_VEC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_pc <= DBITS'(START_PC);
    else if (!bus.stall) r_pc <= w_pc_next;
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Pulse is aligned with the cycle pcOut shows the trap vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= w_misalign & ~bus.stall;
  end
  assign bus.misalign = r_misalign;
`endif

  pc_ras #(
    .DBITS (DBITS),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (reset),
    .i_stall (bus.stall),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_seq),
    .o_top   (w_top),
    .o_full  (bus.rasFull),
    .o_empty (w_empty),
    .o_ovf   (bus.rasOvf),
    .o_unf   (bus.rasUnf)
  );

  assign bus.rasEmpty = w_empty;
  assign bus.pcOut    = r_pc;

endmodule
